// File: rtl/pixel_stream_writer.sv
// Accepts packed pixel words from the HPS over a PIO toggle handshake, buffers them in a
// word FIFO and unpacks 1, 2 or 4 pixels per word into the framebuffer write port.
//
// state    | meaning
// ST_IDLE  | unpacker empty; load the FIFO head as soon as one is present
// ST_EMIT  | presenting the current pixel; advance on fb_we && fb_ready
module pixel_stream_writer #(
  parameter int PIX_W      = 8,
  parameter int FB_WIDTH   = 640,
  parameter int FB_HEIGHT  = 480,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 19
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset_n,
  input  logic [31:0]                   pixel_data_export,
  input  logic [31:0]                   pixel_status_export,
  output logic                          pixel_ack,
  output logic                          fb_we,
  output logic [ADDR_W-1:0]             fb_addr,
  output logic [PIX_W-1:0]              fb_data,
  input  logic                          fb_ready,
  output logic                          frame_done,
  output logic                          sof_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = 35;
  localparam logic [2:0] MAX_PIX = 3'(32 / PIX_W);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WIDTH * FB_HEIGHT - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EMIT = 1'b1;

  logic [ENT_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]  level_q;
  logic              req_q, ack_q, err_q;
  logic [0:0]        state_q;
  logic [31:0]       shift_q;
  logic [2:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;

  logic              clr, fifo_full, fifo_empty, push, pop, xfer, last_pix;
  logic [ENT_W-1:0]  head;
  logic [ADDR_W-1:0] addr_inc, addr_at_pop;
  logic              unused_status;

  function automatic logic [2:0] pix_per_word(input logic [1:0] mode);
    logic [2:0] n;
    case (mode)
      2'b00:   n = 3'd1;
      2'b01:   n = 3'd2;
      default: n = 3'd4;
    endcase
    return (n > MAX_PIX) ? MAX_PIX : n;
  endfunction

  assign unused_status = ^pixel_status_export[30:4];

  assign clr        = pixel_status_export[31];
  assign fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
  assign fifo_empty = (level_q == '0);
  // full is judged on the current occupancy, so a pop in the same cycle does not admit a push
  assign push       = (pixel_status_export[0] != req_q) && !fifo_full && !clr;
  assign xfer       = (state_q == ST_EMIT) && fb_ready;
  assign last_pix   = xfer && (cnt_q == 3'd1);
  assign pop        = !clr && !fifo_empty && ((state_q == ST_IDLE) || last_pix);
  assign head       = mem[rd_ptr_q];
  assign addr_inc   = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
  // address the popped word would start at if it did not carry sof
  assign addr_at_pop = xfer ? addr_inc : addr_q;

  always_ff @(posedge clk_clk) begin
    if (push) mem[wr_ptr_q] <= {pixel_status_export[1], pixel_status_export[3:2], pixel_data_export};
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      req_q    <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      addr_q   <= '0;
    end else if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      req_q    <= pixel_status_export[0];
      err_q    <= 1'b0;
      state_q  <= ST_IDLE;
      addr_q   <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        req_q    <= pixel_status_export[0];
        ack_q    <= ~ack_q;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);

      case ({push, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase

      if (xfer) begin
        shift_q <= shift_q >> PIX_W;
        cnt_q   <= cnt_q - 3'd1;
        addr_q  <= addr_inc;
      end

      if (pop) begin
        shift_q <= head[31:0];
        cnt_q   <= pix_per_word(head[33:32]);
        state_q <= ST_EMIT;
        if (head[34]) begin
          addr_q <= '0;
          if (addr_at_pop != '0) err_q <= 1'b1;
        end
      end else if (last_pix) begin
        state_q <= ST_IDLE;
      end
    end
  end

  assign pixel_ack  = ack_q;
  assign fb_we      = (state_q == ST_EMIT);
  assign fb_addr    = addr_q;
  assign fb_data    = shift_q[PIX_W-1:0];
  assign frame_done = xfer && (addr_q == LAST_ADDR);
  assign sof_err    = err_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_pixel_stream_writer.sv
// Bench for pixel_stream_writer: an order-based pixel model (expected address/data/frame_done
// per pixel) checked on every framebuffer transfer, plus directed literal checks.
module tb_pixel_stream_writer;

  localparam int PIX_W      = 8;
  localparam int FB_WIDTH   = 4;
  localparam int FB_HEIGHT  = 2;
  localparam int FIFO_DEPTH = 16;
  localparam int ADDR_W     = 19;
  localparam int FRAME      = FB_WIDTH * FB_HEIGHT;

  logic              clk_clk = 1'b0;
  logic              reset_reset_n;
  logic [31:0]       pixel_data_export;
  logic [31:0]       pixel_status_export;
  logic              pixel_ack;
  logic              fb_we;
  logic [ADDR_W-1:0] fb_addr;
  logic [PIX_W-1:0]  fb_data;
  logic              fb_ready;
  logic              frame_done;
  logic              sof_err;
  logic [4:0]        fifo_level;

  pixel_stream_writer #(
    .PIX_W(PIX_W), .FB_WIDTH(FB_WIDTH), .FB_HEIGHT(FB_HEIGHT),
    .FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W)
  ) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .pixel_data_export(pixel_data_export), .pixel_status_export(pixel_status_export),
    .pixel_ack(pixel_ack), .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
    .fb_ready(fb_ready), .frame_done(frame_done), .sof_err(sof_err), .fifo_level(fifo_level)
  );

  initial forever #5 clk_clk = ~clk_clk;

  typedef struct {
    int         addr;
    logic [7:0] data;
    logic       last;
  } pix_t;

  pix_t       exp_q[$];
  int         model_addr = 0;
  logic       exp_err = 1'b0;
  logic       exp_ack = 1'b0;
  logic       req = 1'b0;
  int         rdy_mode = 1;
  int         n_cmp = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         fd_cnt = 0;
  int         fd_addr = -1;
  int         log_addr[$];
  logic [7:0] log_data[$];
  int         log_cyc[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected pixels of one word, from the unpack/address rules alone
  task automatic model_word(input logic [31:0] d, input logic [1:0] m, input logic s);
    int   n;
    pix_t p;
    n = (m == 2'd0) ? 1 : (m == 2'd1) ? 2 : 4;
    if (n > 32 / PIX_W) n = 32 / PIX_W;
    if (s) begin
      if (model_addr != 0) exp_err = 1'b1;
      model_addr = 0;
    end
    for (int i = 0; i < n; i++) begin
      p.addr = model_addr;
      p.data = d[8*i +: 8];
      p.last = (model_addr == FRAME - 1);
      exp_q.push_back(p);
      model_addr = (model_addr + 1) % FRAME;
    end
  endtask

  task automatic model_flush();
    exp_q.delete();
    model_addr = 0;
    exp_err    = 1'b0;
  endtask

  task automatic issue(input logic [31:0] d, input logic [1:0] m, input logic s);
    @(posedge clk_clk); #1;
    req = ~req;
    pixel_data_export   = d;
    pixel_status_export = {1'b0, 27'd0, m, s, req};
    model_word(d, m, s);
    exp_ack = ~exp_ack;
  endtask

  task automatic wait_ack(input int limit, input string nm);
    for (int k = 0; k < limit; k++) begin
      @(negedge clk_clk);
      if (pixel_ack == exp_ack) break;
    end
    check(nm, pixel_ack, exp_ack);
  endtask

  task automatic send(input logic [31:0] d, input logic [1:0] m, input logic s, input string nm);
    issue(d, m, s);
    wait_ack(400, nm);
  endtask

  task automatic wait_drain(input int limit, input string nm);
    int k;
    for (k = 0; k < limit; k++) begin
      @(negedge clk_clk);
      if (exp_q.size() == 0 && !fb_we && fifo_level == 0) break;
    end
    check(nm, (k < limit), 1'b1);
  endtask

  task automatic soft_clear();
    @(posedge clk_clk); #1;
    pixel_status_export[31] = 1'b1;
    @(posedge clk_clk); #1;
    model_flush();
    pixel_status_export[31] = 1'b0;
  endtask

  initial forever begin
    @(posedge clk_clk); #1;
    if (rdy_mode == 0)      fb_ready = 1'b0;
    else if (rdy_mode == 1) fb_ready = 1'b1;
    else                    fb_ready = 1'($urandom_range(0, 1));
  end

  // Per-cycle compare against the model, plus hold-stability under backpressure
  initial begin
    pix_t              e;
    logic              prev_hold;
    logic [ADDR_W-1:0] prev_addr;
    logic [7:0]        prev_data;
    prev_hold = 1'b0;
    prev_addr = '0;
    prev_data = '0;
    forever begin
      @(negedge clk_clk);
      cyc++;
      if (fb_we && fb_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %0d data %0h expected no write", fb_addr, fb_data);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", fb_addr, e.addr);
          check("wr_data", fb_data, e.data);
          check("wr_frame_done", frame_done, e.last);
        end
        log_addr.push_back(int'(fb_addr));
        log_data.push_back(fb_data);
        log_cyc.push_back(cyc);
        if (frame_done) begin
          fd_cnt++;
          fd_addr = int'(fb_addr);
        end
      end else begin
        check("idle_frame_done", frame_done, 1'b0);
      end
      if (prev_hold) begin
        check("hold_we", fb_we, 1'b1);
        check("hold_addr", fb_addr, prev_addr);
        check("hold_data", fb_data, prev_data);
      end
      prev_hold = fb_we && !fb_ready && reset_reset_n && !pixel_status_export[31];
      prev_addr = fb_addr;
      prev_data = fb_data;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  t2_exp [8];
    logic [7:0]  first_px;
    logic        saved_ack;
    logic [31:0] d;
    logic [1:0]  m;
    logic        s;
    int          k;

    reset_reset_n       = 1'b0;
    pixel_data_export   = '0;
    pixel_status_export = '0;
    fb_ready            = 1'b1;
    repeat (3) @(posedge clk_clk);
    #1 reset_reset_n = 1'b1;

    @(negedge clk_clk);
    check("rst_we", fb_we, 1'b0);
    check("rst_addr", fb_addr, 0);
    check("rst_data", fb_data, 0);
    check("rst_ack", pixel_ack, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_sof_err", sof_err, 1'b0);
    check("rst_level", fifo_level, 0);

    // Single pixel, exact handshake latency
    issue(32'h0000_00AB, 2'b00, 1'b0);
    @(negedge clk_clk);
    check("t1_ack_c", pixel_ack, 1'b0);
    @(negedge clk_clk);
    check("t1_ack_c1", pixel_ack, 1'b1);
    check("t1_we_c1", fb_we, 1'b0);
    @(negedge clk_clk);
    check("t1_we_c2", fb_we, 1'b1);
    check("t1_addr_c2", fb_addr, 0);
    check("t1_data_c2", fb_data, 8'hAB);
    wait_drain(50, "t1_drain");

    // Two 4-pixel words back to back
    soft_clear();
    log_addr.delete(); log_data.delete(); log_cyc.delete();
    t2_exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send(32'h4433_2211, 2'b10, 1'b0, "t2_ack1");
    send(32'h8877_6655, 2'b10, 1'b0, "t2_ack2");
    wait_drain(50, "t2_drain");
    check("t2_count", log_data.size(), 8);
    for (int i = 0; i < 8 && i < log_data.size(); i++) begin
      check("t2_addr", log_addr[i], i);
      check("t2_data", log_data[i], t2_exp[i]);
      check("t2_gapless", log_cyc[i] - log_cyc[0], i);
    end

    // Backpressure: one word in the unpacker plus a full FIFO, then a blocked request
    rdy_mode = 0;
    repeat (2) @(posedge clk_clk);
    soft_clear();
    log_addr.delete(); log_data.delete(); log_cyc.delete();
    first_px = 8'h00;
    for (int i = 0; i < 17; i++) begin
      d = {24'd0, 8'($urandom_range(1, 255))};
      if (i == 0) first_px = d[7:0];
      send(d, 2'b00, 1'b0, "bp_ack");
    end
    @(negedge clk_clk);
    check("bp_level", fifo_level, 16);
    check("bp_we", fb_we, 1'b1);
    check("bp_addr", fb_addr, 0);
    check("bp_data", fb_data, first_px);
    saved_ack = exp_ack;
    issue(32'h0000_00C3, 2'b00, 1'b0);
    repeat (10) @(negedge clk_clk);
    check("bp_ack_held", pixel_ack, saved_ack);
    check("bp_level_held", fifo_level, 16);
    rdy_mode = 1;
    wait_ack(50, "bp_ack_late");
    wait_drain(100, "bp_drain");
    check("bp_count", log_data.size(), 18);

    // Frame wrap at 4x2
    soft_clear();
    log_addr.delete(); log_data.delete(); log_cyc.delete();
    fd_cnt = 0;
    fd_addr = -1;
    send(32'h0403_0201, 2'b10, 1'b0, "fw_ack");
    send(32'h0807_0605, 2'b10, 1'b0, "fw_ack");
    send(32'h0C0B_0A09, 2'b10, 1'b0, "fw_ack");
    wait_drain(100, "fw_drain");
    check("fw_count", log_data.size(), 12);
    check("fw_pulses", fd_cnt, 1);
    check("fw_pulse_addr", fd_addr, 7);
    if (log_addr.size() > 8) check("fw_ninth_addr", log_addr[8], 0);

    // sof arriving mid-frame
    soft_clear();
    log_addr.delete(); log_data.delete(); log_cyc.delete();
    send(32'h0000_0001, 2'b00, 1'b0, "sof_ack");
    send(32'h0000_0302, 2'b01, 1'b0, "sof_ack");
    send(32'hDDCC_BBAA, 2'b10, 1'b1, "sof_ack");
    wait_drain(100, "sof_drain");
    check("sof_err_set", sof_err, 1'b1);
    check("sof_err_model", sof_err, exp_err);
    if (log_addr.size() > 3) begin
      check("sof_first_addr", log_addr[3], 0);
      check("sof_first_data", log_data[3], 8'hAA);
    end
    rdy_mode = 0;
    repeat (2) @(posedge clk_clk);
    send(32'h0000_0011, 2'b00, 1'b0, "sof_ack2");
    send(32'h0000_0022, 2'b00, 1'b0, "sof_ack2");
    @(negedge clk_clk);
    check("sof_level_pre_clr", fifo_level, 1);
    soft_clear();
    @(negedge clk_clk);
    check("clr_sof_err", sof_err, 1'b0);
    check("clr_level", fifo_level, 0);
    check("clr_we", fb_we, 1'b0);
    rdy_mode = 1;
    repeat (2) @(posedge clk_clk);

    // Reset while the second pixel of a 4-pixel word is presented
    log_addr.delete(); log_data.delete(); log_cyc.delete();
    issue(32'hD4C3_B2A1, 2'b10, 1'b0);
    for (k = 0; k < 10; k++) begin
      @(negedge clk_clk);
      if (fb_we) break;
    end
    check("rm_first_we", (k < 10), 1'b1);
    @(posedge clk_clk); #1;
    reset_reset_n       = 1'b0;
    pixel_status_export = '0;
    req                 = 1'b0;
    @(posedge clk_clk); #1;
    model_flush();
    exp_ack = 1'b0;
    @(negedge clk_clk);
    check("rm_we", fb_we, 1'b0);
    check("rm_level", fifo_level, 0);
    check("rm_ack", pixel_ack, 1'b0);
    @(posedge clk_clk); #1 reset_reset_n = 1'b1;
    log_addr.delete(); log_data.delete(); log_cyc.delete();
    send(32'h0000_005A, 2'b00, 1'b0, "rm_ack_after");
    wait_drain(50, "rm_drain");
    check("rm_count", log_data.size(), 1);
    if (log_addr.size() > 0) begin
      check("rm_addr", log_addr[0], 0);
      check("rm_data", log_data[0], 8'h5A);
    end

    // Randomized words, modes, sof and fb_ready
    rdy_mode = 2;
    for (int i = 0; i < 60; i++) begin
      d = $urandom;
      m = 2'($urandom_range(0, 3));
      s = ($urandom_range(0, 7) == 0);
      send(d, m, s, "rnd_ack");
      repeat ($urandom_range(0, 3)) @(posedge clk_clk);
    end
    wait_drain(2000, "rnd_drain");
    check("rnd_sof_err", sof_err, exp_err);
    check("rnd_level", fifo_level, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
